// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM playback sequencer with tempo, pause and end-of-track detection
module note_sequencer #(
    parameter int         IDX_W     = 6,
    parameter int         TEMPO_DIV = 12500000,
    parameter int         AUTOPLAY  = 1,
    parameter logic [7:0] END_CODE  = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       select,
    input  logic             pause,
    input  logic [7:0]       rom_data,
    output logic [IDX_W+1:0] rom_addr,
    output logic [7:0]       note_out,
    output logic             note_valid,
    output logic             playing,
    output logic             paused,
    output logic             song_end,
    output logic             next_req
);

    localparam int CNT_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
    localparam logic [CNT_W-1:0] TEMPO_LOAD = CNT_W'(TEMPO_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        PLAY   = 3'd3,
        PAUSED = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       track_q, track_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] tempo_q, tempo_d;
    logic [7:0]       note_q, note_d;
    logic             pause_prev_q;
    logic             song_end_q, song_end_d;
    logic             next_req_q, next_req_d;
    logic             pause_edge;

    // State and datapath registers; pause history always tracks the raw level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            track_q      <= '0;
            idx_q        <= '0;
            tempo_q      <= '0;
            note_q       <= '0;
            pause_prev_q <= 1'b0;
            song_end_q   <= 1'b0;
            next_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            idx_q        <= idx_d;
            tempo_q      <= tempo_d;
            note_q       <= note_d;
            pause_prev_q <= pause;
            song_end_q   <= song_end_d;
            next_req_q   <= next_req_d;
        end
    end

    // Next-state logic: start overrides everything, then per-state behaviour
    always_comb begin
        state_d    = state_q;
        track_d    = track_q;
        idx_d      = idx_q;
        tempo_d    = tempo_q;
        note_d     = note_q;
        pause_edge = pause & ~pause_prev_q;

        if (start) begin
            track_d = select;
            idx_d   = '0;
            tempo_d = '0;
            note_d  = '0;
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_data == END_CODE) begin
                        state_d = DONE;
                    end else begin
                        note_d  = rom_data;
                        tempo_d = TEMPO_LOAD;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    // The last PLAY cycle of a note always advances; a pause edge
                    // there is dropped so a note never exceeds TEMPO_DIV PLAY cycles.
                    if (tempo_q == '0) begin
                        if (&idx_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        // The cycle in which pause is seen still counts as played.
                        tempo_d = tempo_q - 1'b1;
                        if (pause_edge) begin
                            state_d = PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_edge) begin
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    note_d  = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered so the pulse lines up exactly with the DONE cycle.
        song_end_d = (state_d == DONE);
        next_req_d = (state_d == DONE) && (AUTOPLAY != 0);
    end

    assign rom_addr   = {track_q, idx_q};
    assign note_out   = note_q;
    assign note_valid = (state_q == PLAY) && (note_q != 8'h00);
    assign playing    = (state_q == FETCH) || (state_q == LOAD) || (state_q == PLAY);
    assign paused     = (state_q == PAUSED);
    assign song_end   = song_end_q;
    assign next_req   = next_req_q;

endmodule
